// File: rtl/clock_period_meter.sv
// Measures the high, low and full period of a slow sampled clock in system-clock cycles.
// It also flags a stable period (locked) and a stalled input clock (timeout).
module clock_period_meter #(
    parameter int W           = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_clk,
    output logic [W-1:0] high_cycles,
    output logic [W-1:0] low_cycles,
    output logic [W:0]   period,
    output logic         meas_valid,
    output logic         locked,
    output logic         timeout
);

    localparam logic [W-1:0] CNT_MAX  = '1;
    localparam int           LW       = $clog2(LOCK_COUNT + 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        MEAS_HIGH  = 2'd1,
        MEAS_LOW   = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [W-1:0]           r_hcnt;
    logic [W-1:0]           r_lcnt;
    logic [W-1:0]           w_hcnt_next;
    logic [W-1:0]           w_lcnt_next;
    logic                   w_publish;
    logic                   w_expire;

    logic [W:0]             w_period_new;
    logic [LW-1:0]          r_lock_cnt;
    logic [LW-1:0]          w_lock_cnt_next;

    logic [W-1:0]           r_high;
    logic [W-1:0]           r_low;
    logic [W:0]             r_period;
    logic                   r_meas_valid;
    logic                   r_locked;
    logic                   r_timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_clk};
            r_s_d  <= w_s;
        end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_s_d;
    assign w_fall = ~w_s & r_s_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= WAIT_FIRST;
            r_hcnt  <= '0;
            r_lcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_hcnt  <= w_hcnt_next;
            r_lcnt  <= w_lcnt_next;
        end
    end

    // A saturated phase counter means the input stalled; drop back and wait for a clean rise.
    always_comb begin
        w_state_next = r_state;
        w_hcnt_next  = r_hcnt;
        w_lcnt_next  = r_lcnt;
        w_publish    = 1'b0;
        w_expire     = 1'b0;
        case (r_state)
            WAIT_FIRST: begin
                if (w_rise) begin
                    w_state_next = MEAS_HIGH;
                    w_hcnt_next  = W'(1);
                end
            end
            MEAS_HIGH: begin
                if (w_fall) begin
                    w_state_next = MEAS_LOW;
                    w_lcnt_next  = W'(1);
                end else if (r_hcnt == CNT_MAX) begin
                    w_state_next = WAIT_FIRST;
                    w_expire     = 1'b1;
                end else begin
                    w_hcnt_next = r_hcnt + W'(1);
                end
            end
            MEAS_LOW: begin
                if (w_rise) begin
                    w_state_next = MEAS_HIGH;
                    w_hcnt_next  = W'(1);
                    w_publish    = 1'b1;
                end else if (r_lcnt == CNT_MAX) begin
                    w_state_next = WAIT_FIRST;
                    w_expire     = 1'b1;
                end else begin
                    w_lcnt_next = r_lcnt + W'(1);
                end
            end
            default: begin
                w_state_next = WAIT_FIRST;
            end
        endcase
    end

    assign w_period_new = {1'b0, r_hcnt} + {1'b0, r_lcnt};

    // A zero lock count marks "no previous period to compare against".
    always_comb begin
        w_lock_cnt_next = LW'(1);
        if ((r_lock_cnt != '0) && (w_period_new == r_period)) begin
            w_lock_cnt_next = (r_lock_cnt == LOCK_MAX) ? LOCK_MAX : r_lock_cnt + LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_high       <= '0;
            r_low        <= '0;
            r_period     <= '0;
            r_meas_valid <= 1'b0;
            r_locked     <= 1'b0;
            r_timeout    <= 1'b0;
            r_lock_cnt   <= '0;
        end else begin
            r_meas_valid <= w_publish;
            if (w_publish) begin
                r_high     <= r_hcnt;
                r_low      <= r_lcnt;
                r_period   <= w_period_new;
                r_lock_cnt <= w_lock_cnt_next;
                r_locked   <= (w_lock_cnt_next == LOCK_MAX);
                r_timeout  <= 1'b0;
            end else if (w_expire) begin
                r_timeout  <= 1'b1;
                r_locked   <= 1'b0;
                r_lock_cnt <= '0;
            end
        end
    end

    assign high_cycles = r_high;
    assign low_cycles  = r_low;
    assign period      = r_period;
    assign meas_valid  = r_meas_valid;
    assign locked      = r_locked;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_clock_period_meter.sv
// Randomised and directed bench for clock_period_meter; expected pulses come from a
// phase-timing model that works purely from the sample edges at which in_clk changes.
module tb_clock_period_meter;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int LC   = 4;
    localparam int MAXC = (1 << W) - 1;

    typedef struct packed {
        logic [31:0] edge_n;
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [8:0]  per;
        logic        lk;
        logic        to;
    } pulse_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_clk = 1'b0;
    logic [W-1:0] high_cycles;
    logic [W-1:0] low_cycles;
    logic [W:0]   period;
    logic         meas_valid;
    logic         locked;
    logic         timeout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    pulse_t obs_q[$];
    pulse_t exp_q[$];

    // Model state: edges are sample-edge indices at which in_clk changed.
    logic m_level = 1'b0;
    bit   m_armed = 0;
    bit   m_fell = 0;
    int   m_rise_k = 0;
    int   m_fall_k = 0;
    int   m_lock = 0;
    int   m_last_h = 0;
    int   m_last_l = 0;
    int   m_last_p = 0;
    bit   m_timeout = 0;

    clock_period_meter #(
        .W(W),
        .SYNC_STAGES(SYNC),
        .LOCK_COUNT(LC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_clk(in_clk),
        .high_cycles(high_cycles),
        .low_cycles(low_cycles),
        .period(period),
        .meas_valid(meas_valid),
        .locked(locked),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && meas_valid === 1'b1) begin
            obs_q.push_back('{edge_n: cyc, hi: high_cycles, lo: low_cycles, per: period,
                              lk: locked, to: timeout});
        end
    end

    task automatic model_edge(input logic level, input int k);
        pulse_t e;
        int h, l, p;
        if (level) begin
            if (m_armed && m_fell) begin
                h = m_fall_k - m_rise_k;
                l = k - m_fall_k;
                p = h + l;
                if (m_lock != 0 && p == m_last_p) m_lock = (m_lock < LC) ? m_lock + 1 : LC;
                else m_lock = 1;
                m_last_h = h;
                m_last_l = l;
                m_last_p = p;
                m_timeout = 0;
                e.edge_n = k + SYNC;
                e.hi = h[7:0];
                e.lo = l[7:0];
                e.per = p[8:0];
                e.lk = (m_lock == LC);
                e.to = 1'b0;
                exp_q.push_back(e);
            end
            m_armed = 1;
            m_rise_k = k;
            m_fell = 0;
        end else if (m_armed) begin
            m_fall_k = k;
            m_fell = 1;
        end
        m_level = level;
    endtask

    // Hold in_clk at level for n sample edges; the first sample is at edge cyc+1.
    task automatic drive_phase(input logic level, input int n);
        int k;
        k = cyc + 1;
        in_clk = level;
        if (level != m_level) model_edge(level, k);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_clk = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({high_cycles, low_cycles, period, meas_valid, locked, timeout} !== '0) begin
            errors++;
            $display("FAIL reset_in h=%0d l=%0d p=%0d v=%0b lk=%0b to=%0b want all 0",
                     high_cycles, low_cycles, period, meas_valid, locked, timeout);
        end
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({high_cycles, low_cycles, period, meas_valid, locked, timeout, obs_q.size() == 0} !== {{(3*W+4){1'b0}}, 1'b1}) begin
            errors++;
            $display("FAIL reset_out h=%0d l=%0d p=%0d lk=%0b to=%0b pulses=%0d want all 0",
                     high_cycles, low_cycles, period, locked, timeout, obs_q.size());
        end
    endtask

    task automatic test_div8;
        repeat (6) begin
            drive_phase(1'b1, 8);
            drive_phase(1'b0, 8);
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL div8 pulse_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL div8 pulse%0d got e=%0d h=%0d l=%0d p=%0d lk=%0b to=%0b want e=%0d h=%0d l=%0d p=%0d lk=%0b to=%0b",
                         i, obs_q[i].edge_n, obs_q[i].hi, obs_q[i].lo, obs_q[i].per, obs_q[i].lk, obs_q[i].to,
                         exp_q[i].edge_n, exp_q[i].hi, exp_q[i].lo, exp_q[i].per, exp_q[i].lk, exp_q[i].to);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_asymmetric;
        repeat (6) begin
            drive_phase(1'b1, 3);
            drive_phase(1'b0, 5);
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL asym pulse_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL asym pulse%0d got e=%0d h=%0d l=%0d p=%0d lk=%0b want e=%0d h=%0d l=%0d p=%0d lk=%0b",
                         i, obs_q[i].edge_n, obs_q[i].hi, obs_q[i].lo, obs_q[i].per, obs_q[i].lk,
                         exp_q[i].edge_n, exp_q[i].hi, exp_q[i].lo, exp_q[i].per, exp_q[i].lk);
            end
        end
        checks++;
        if (timeout !== m_timeout) begin
            errors++;
            $display("FAIL asym timeout got %0b want %0b", timeout, m_timeout);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_relock;
        repeat (6) begin
            drive_phase(1'b1, 8);
            drive_phase(1'b0, 8);
        end
        repeat (6) begin
            drive_phase(1'b1, 12);
            drive_phase(1'b0, 12);
        end
        drive_phase(1'b1, 4);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL relock pulse_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL relock pulse%0d got e=%0d h=%0d l=%0d p=%0d lk=%0b want e=%0d h=%0d l=%0d p=%0d lk=%0b",
                         i, obs_q[i].edge_n, obs_q[i].hi, obs_q[i].lo, obs_q[i].per, obs_q[i].lk,
                         exp_q[i].edge_n, exp_q[i].hi, exp_q[i].lo, exp_q[i].per, exp_q[i].lk);
            end
        end
        checks++;
        if (locked !== (m_lock == LC)) begin
            errors++;
            $display("FAIL relock locked got %0b want %0b", locked, (m_lock == LC));
        end
        obs_q.delete();
        exp_q.delete();
        drive_phase(1'b0, 8);
    endtask

    task automatic test_timeout;
        int k;
        int t_edge;
        repeat (6) begin
            drive_phase(1'b1, 8);
            drive_phase(1'b0, 8);
        end
        k = cyc + 1;
        in_clk = 1'b1;
        model_edge(1'b1, k);
        t_edge = -1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (timeout === 1'b1 && t_edge < 0) t_edge = cyc;
        end
        m_armed = 0;
        m_lock = 0;
        m_timeout = 1;
        checks++;
        if (t_edge !== k + SYNC + MAXC) begin
            errors++;
            $display("FAIL timeout_edge got %0d want %0d", t_edge, k + SYNC + MAXC);
        end
        checks++;
        if ({timeout, locked, high_cycles, low_cycles, period} !==
            {m_timeout, (m_lock == LC), m_last_h[7:0], m_last_l[7:0], m_last_p[8:0]}) begin
            errors++;
            $display("FAIL timeout_hold got to=%0b lk=%0b h=%0d l=%0d p=%0d want to=1 lk=0 h=%0d l=%0d p=%0d",
                     timeout, locked, high_cycles, low_cycles, period, m_last_h, m_last_l, m_last_p);
        end
        drive_phase(1'b0, 8);
        drive_phase(1'b1, 8);
        drive_phase(1'b0, 8);
        checks++;
        if (timeout !== m_timeout) begin
            errors++;
            $display("FAIL timeout_sticky got %0b want %0b", timeout, m_timeout);
        end
        drive_phase(1'b1, 8);
        drive_phase(1'b0, 8);
        checks++;
        if (timeout !== m_timeout) begin
            errors++;
            $display("FAIL timeout_clear got %0b want %0b", timeout, m_timeout);
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL timeout pulse_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL timeout pulse%0d got e=%0d h=%0d l=%0d p=%0d lk=%0b to=%0b want e=%0d h=%0d l=%0d p=%0d lk=%0b to=%0b",
                         i, obs_q[i].edge_n, obs_q[i].hi, obs_q[i].lo, obs_q[i].per, obs_q[i].lk, obs_q[i].to,
                         exp_q[i].edge_n, exp_q[i].hi, exp_q[i].lo, exp_q[i].per, exp_q[i].lk, exp_q[i].to);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_one_cycle;
        repeat (10) begin
            drive_phase(1'b1, 1);
            drive_phase(1'b0, 1);
        end
        drive_phase(1'b1, 1);
        drive_phase(1'b0, 4);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL one_cycle pulse_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL one_cycle pulse%0d got e=%0d h=%0d l=%0d p=%0d lk=%0b want e=%0d h=%0d l=%0d p=%0d lk=%0b",
                         i, obs_q[i].edge_n, obs_q[i].hi, obs_q[i].lo, obs_q[i].per, obs_q[i].lk,
                         exp_q[i].edge_n, exp_q[i].hi, exp_q[i].lo, exp_q[i].per, exp_q[i].lk);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random;
        int h, l, reps;
        for (int r = 0; r < 6; r++) begin
            h = $urandom_range(1, 20);
            l = $urandom_range(1, 20);
            reps = $urandom_range(2, 6);
            repeat (reps) begin
                drive_phase(1'b1, h);
                drive_phase(1'b0, l);
            end
        end
        drive_phase(1'b1, 4);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL random pulse_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random pulse%0d got e=%0d h=%0d l=%0d p=%0d lk=%0b want e=%0d h=%0d l=%0d p=%0d lk=%0b",
                         i, obs_q[i].edge_n, obs_q[i].hi, obs_q[i].lo, obs_q[i].per, obs_q[i].lk,
                         exp_q[i].edge_n, exp_q[i].hi, exp_q[i].lo, exp_q[i].per, exp_q[i].lk);
            end
        end
        checks++;
        if ({locked, timeout} !== {(m_lock == LC), m_timeout}) begin
            errors++;
            $display("FAIL random flags got lk=%0b to=%0b want lk=%0b to=%0b",
                     locked, timeout, (m_lock == LC), m_timeout);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_phase;
        repeat (3) begin
            drive_phase(1'b1, 8);
            drive_phase(1'b0, 8);
        end
        drive_phase(1'b1, 5);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL midrst pre_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        obs_q.delete();
        exp_q.delete();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({high_cycles, low_cycles, period, meas_valid, locked, timeout} !== '0) begin
            errors++;
            $display("FAIL midrst_async h=%0d l=%0d p=%0d v=%0b lk=%0b to=%0b want all 0",
                     high_cycles, low_cycles, period, meas_valid, locked, timeout);
        end
        in_clk = 1'b0;
        m_level = 1'b0;
        m_armed = 0;
        m_fell = 0;
        m_lock = 0;
        m_timeout = 0;
        #9 rst = 1'b1;
        @(posedge clk);
        #1;
        drive_phase(1'b0, 4);
        drive_phase(1'b1, 6);
        drive_phase(1'b0, 6);
        checks++;
        if (obs_q.size() !== 0) begin
            errors++;
            $display("FAIL midrst_one_rise pulses got %0d want 0", obs_q.size());
        end
        drive_phase(1'b1, 6);
        drive_phase(1'b0, 6);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL midrst pulse_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midrst pulse%0d got e=%0d h=%0d l=%0d p=%0d lk=%0b want e=%0d h=%0d l=%0d p=%0d lk=%0b",
                         i, obs_q[i].edge_n, obs_q[i].hi, obs_q[i].lo, obs_q[i].per, obs_q[i].lk,
                         exp_q[i].edge_n, exp_q[i].hi, exp_q[i].lo, exp_q[i].per, exp_q[i].lk);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_div8();
        test_asymmetric();
        test_relock();
        test_timeout();
        test_one_cycle();
        test_random();
        test_reset_mid_phase();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
